fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns and sequences the program counter.
- Chooses the next address: sequential, redirect (branch/jump) or interrupt vector.
- Runs a single-outstanding req/gnt/rvalid handshake to instruction memory.
- Presents each fetched word with its address to decode through a stallable output register. Sits between the datapath control unit and instruction memory.

Parameters:
ADDR_WIDTH, 12, PC / memory address width
DATA_WIDTH, 16, instruction word width
RESET_VECTOR, 12'h000, PC value after reset and on start from IDLE
IRQ_VECTOR, 12'hFF0, PC loaded when an interrupt is taken

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE or HALTED and begin fetching
halt  in  1  level; stop after the current fetch completes
stall  in  1  decode not ready; hold the output register
redirect_valid  in  1  one-cycle branch/jump request
redirect_addr  in  ADDR_WIDTH  redirect target
irq  in  1  level interrupt request, held until irq_ack
imem_req  out  1  memory request
imem_addr  out  ADDR_WIDTH  request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; earliest one cycle after gnt
imem_rdata  in  DATA_WIDTH  read data
fetch_valid  out  1  fetch_instr and fetch_pc valid
fetch_pc  out  ADDR_WIDTH  address of the presented instruction
fetch_instr  out  DATA_WIDTH  presented instruction
irq_ack  out  1  one-cycle pulse when the interrupt is taken
epc  out  ADDR_WIDTH  return address saved on interrupt
busy  out  1  high in REQ or WAIT

Behaviour:
- Reset (synchronous, active-high), overrides everything:
  - state=IDLE, pc=RESET_VECTOR, drop=0.
  - fetch_valid=0, fetch_pc=0, fetch_instr=0.
  - irq_ack=0, epc=0, imem_req=0, busy=0.
  - Reset mid-transaction abandons it; a later imem_rvalid is ignored in IDLE.
- States:
  - IDLE: start loads pc=RESET_VECTOR and moves to REQ.
  - REQ:
    - imem_req=1 only when the slot is free: !fetch_valid || !stall.
    - imem_addr=pc, stable while imem_req && !imem_gnt.
    - imem_gnt moves to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid, the fetch completes and the next-PC rule applies.
    - Then go to HALTED if halt=1, otherwise REQ.
  - HALTED: imem_req=0, busy=0, pc retained; start moves to REQ and resumes at pc.
- Output slot:
  - Consumed when fetch_valid && !stall.
  - On a non-dropped rvalid, the next cycle has fetch_valid=1, fetch_pc=pc and fetch_instr=imem_rdata.
  - Otherwise fetch_valid clears when the slot is consumed and is held while stall=1.
  - Because the request is gated on a free slot, the slot is always free at rvalid; there is no overwrite.
- Next-PC rule on a non-dropped completion, in priority order:
  1. redirect_valid: pc=redirect_addr.
  2. irq: epc=pc+1, pc=IRQ_VECTOR, irq_ack=1 for one cycle.
  3. Otherwise pc=pc+1.
- Arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH (12'hFFF -> 12'h000).
- Redirect in REQ or WAIT:
  - pc=redirect_addr.
  - fetch_valid cleared next cycle (flush).
  - If a grant is outstanding (state WAIT, or gnt in the same cycle), set drop=1. The matching rvalid is discarded and clears drop; nothing is presented and the next-PC rule is skipped.
  - Redirect while dropping: retarget pc only.
  - Redirect is ignored in IDLE and HALTED.
- Interrupt timing:
  - Not taken on a dropped completion or while redirect_valid=1; it stays pending.
  - At most one irq_ack per completion.
- halt in REQ before grant: go straight to HALTED; no request is issued that cycle.
- start while busy is ignored.
- Latency: start sampled at cycle t -> imem_req=1 at t+1. With gnt at t+1 and rvalid at t+2, fetch_valid=1 at t+3.

Test Plan:
- Reset, start, memory returning one cycle after gnt, stall=0 -> fetch_pc sequence 0x000, 0x001, 0x002; one fetch every 2 cycles after the first; rdata passes through.
- pc preloaded near the top (redirect to 0xFFE) -> fetch_pc 0xFFE, 0xFFF, 0x000 (wrap).
- stall held 5 cycles with fetch_valid=1 -> fetch_pc/fetch_instr stable; imem_req=0 throughout; resumes the cycle stall drops.
- redirect_valid with redirect_addr=0x123 while in WAIT -> the in-flight rvalid is not presented; next imem_addr=0x123; fetch_valid flushed.
- irq raised while fetching 0x010 -> irq_ack pulses once; epc=0x011; next imem_addr=0xFF0. irq asserted together with redirect -> redirect wins, irq taken on the following completion.
- halt during WAIT at pc 0x005 -> rvalid presented, state HALTED, imem_req=0, busy=0; start -> imem_addr=0x006. reset asserted in WAIT -> all outputs return to reset values the next cycle and the late rvalid is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and presents words to decode.
module fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(12'h000),
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = ADDR_WIDTH'(12'hFF0)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  irq,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  irq_ack,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
    logic                  irq_ack_q, irq_ack_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic                  busy_q, busy_d;

    logic                  slot_free_c;
    logic                  req_c;
    logic                  gnt_acc_c;
    logic [ADDR_WIDTH-1:0] pc_inc_c;

    // Request only when the output slot can take the returning word.
    assign slot_free_c = !fetch_valid_q || !stall;
    assign req_c       = (state_q == S_REQ) && slot_free_c && !halt;
    assign gnt_acc_c   = req_c && imem_gnt;
    assign pc_inc_c    = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        irq_ack_d     = 1'b0;
        epc_d         = epc_q;

        if (fetch_valid_q && !stall) begin
            fetch_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = RESET_VECTOR;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d          = redirect_addr;
                    fetch_valid_d = 1'b0;
                    if (gnt_acc_c) begin
                        drop_d = 1'b1;
                    end
                end
                if (halt) begin
                    state_d = S_HALTED;
                end else if (gnt_acc_c) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        // Word belongs to the path abandoned by a redirect.
                        drop_d = 1'b0;
                        if (redirect_valid) begin
                            pc_d = redirect_addr;
                        end
                    end else begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_instr_d = imem_rdata;
                        if (redirect_valid) begin
                            pc_d = redirect_addr;
                        end else if (irq) begin
                            epc_d     = pc_inc_c;
                            pc_d      = IRQ_VECTOR;
                            irq_ack_d = 1'b1;
                        end else begin
                            pc_d = pc_inc_c;
                        end
                    end
                    state_d = halt ? S_HALTED : S_REQ;
                end else if (redirect_valid) begin
                    pc_d = redirect_addr;
                    if (!drop_q) begin
                        fetch_valid_d = 1'b0;
                        drop_d        = 1'b1;
                    end
                end
            end

            S_HALTED: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_REQ) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            drop_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_instr_q <= '0;
            irq_ack_q     <= 1'b0;
            epc_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            irq_ack_q     <= irq_ack_d;
            epc_q         <= epc_d;
            busy_q        <= busy_d;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_instr = fetch_instr_q;
    assign irq_ack     = irq_ack_q;
    assign epc         = epc_q;
    assign busy        = busy_q;

endmodule
